// File: rtl/btn_debounce_multi_if.sv
// ----------------------------------------------------------------------------
// btn_debounce_multi_if
// Bundles the sample tick, the raw button inputs and the debounced outputs
// of btn_debounce_multi into one interface.
//
// Signals:
//   i_ena      sample-tick strobe, one clock wide
//   i_btn      raw asynchronous button inputs, active-high
//   o_state    debounced level per channel
//   o_press    one-clock pulse on an accepted 0->1 transition
//   o_release  one-clock pulse on an accepted 1->0 transition
//   o_repeat   one-clock auto-repeat pulse (0 when auto-repeat is not built)
//
// Modports:
//   master  the button / tick source that observes the results
//   slave   the debouncer itself
// ----------------------------------------------------------------------------
interface btn_debounce_multi_if #(
  parameter int N_BTN = 4
);

  logic             i_ena;
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_state;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_repeat;

  modport master (
    output i_ena,
    output i_btn,
    input  o_state,
    input  o_press,
    input  o_release,
    input  o_repeat
  );

  modport slave (
    input  i_ena,
    input  i_btn,
    output o_state,
    output o_press,
    output o_release,
    output o_repeat
  );

endinterface

// File: rtl/btn_debounce_multi.sv
// ----------------------------------------------------------------------------
// btn_debounce_multi
// Multi-channel button debouncer for the clock-setting UI. Every channel
// synchronises its raw input through two flops and accepts a new level only
// after it has persisted for STABLE_TICKS consecutive i_ena ticks. Accepted
// transitions produce registered one-clock press / release pulses.
//
// Optional feature (macro BTN_AUTO_REPEAT_EN): a per-channel IDLE/HOLD/RPT
// state machine emits o_repeat pulses while a button stays held, first
// HOLD_TICKS ticks after the press, then every REPEAT_TICKS ticks. Without
// the macro no repeat logic exists and o_repeat is tied to 0.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset, takes priority over i_ena
//   bus_if  btn_debounce_multi_if.slave: i_ena, i_btn in;
//           o_state, o_press, o_release, o_repeat out
// ----------------------------------------------------------------------------
module btn_debounce_multi #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 5,
  parameter int HOLD_TICKS   = 250,
  parameter int REPEAT_TICKS = 50
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  btn_debounce_multi_if.slave   bus_if
);

  // Counter only has to reach STABLE_TICKS-1, so it can never wrap.
  localparam int                CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  // Illegal parameter values would silently break the counters.
  if ((STABLE_TICKS < 1) || (HOLD_TICKS < 1) || (REPEAT_TICKS < 1)) begin : g_param_check
    $error("btn_debounce_multi: tick parameters must be >= 1");
  end

  logic [N_BTN-1:0] sync1_q,   sync1_d;
  logic [N_BTN-1:0] sync2_q,   sync2_d;
  logic [N_BTN-1:0] state_q,   state_d;
  logic [N_BTN-1:0] press_q,   press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Next-state of synchronisers, stable counters, debounced level and pulses.
  always_comb begin
    sync1_d   = sync1_q;
    sync2_d   = sync2_q;
    state_d   = state_q;
    press_d   = {N_BTN{1'b0}};
    release_d = {N_BTN{1'b0}};
    for (int k = 0; k < N_BTN; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (bus_if.i_ena) begin
      sync1_d = bus_if.i_btn;
      sync2_d = sync1_q;
      for (int k = 0; k < N_BTN; k++) begin
        if (sync2_q[k] == state_q[k]) begin
          // Input agrees with the accepted level: any partial run is discarded.
          cnt_d[k] = {CNT_W{1'b0}};
        end else if (cnt_q[k] == CNT_LAST) begin
          state_d[k]   = sync2_q[k];
          cnt_d[k]     = {CNT_W{1'b0}};
          press_d[k]   = sync2_q[k];
          release_d[k] = ~sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end else begin
      // No tick: everything holds and the pulse defaults stay low.
      sync1_d = sync1_q;
    end
  end

  // Debounce state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= {N_BTN{1'b0}};
      sync2_q   <= {N_BTN{1'b0}};
      state_q   <= {N_BTN{1'b0}};
      press_q   <= {N_BTN{1'b0}};
      release_q <= {N_BTN{1'b0}};
      for (int k = 0; k < N_BTN; k++) begin
        cnt_q[k] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < N_BTN; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus_if.o_state   = state_q;
  assign bus_if.o_press   = press_q;
  assign bus_if.o_release = release_q;

`ifdef BTN_AUTO_REPEAT_EN

  localparam int RMAX   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int RCNT_W = $clog2(RMAX + 1);
  localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(HOLD_TICKS - 1);
  localparam logic [RCNT_W-1:0] RPT_LAST  = RCNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_RPT  = 2'b10
  } rpt_state_e;

  rpt_state_e        rpt_q  [N_BTN];
  rpt_state_e        rpt_d  [N_BTN];
  logic [RCNT_W-1:0] rcnt_q [N_BTN];
  logic [RCNT_W-1:0] rcnt_d [N_BTN];
  logic [N_BTN-1:0]  repeat_q, repeat_d;

  // Auto-repeat next-state: follows the same-tick press/release decisions.
  always_comb begin
    repeat_d = {N_BTN{1'b0}};
    for (int k = 0; k < N_BTN; k++) begin
      rpt_d[k]  = rpt_q[k];
      rcnt_d[k] = rcnt_q[k];
    end
    if (bus_if.i_ena) begin
      for (int k = 0; k < N_BTN; k++) begin
        if (release_d[k]) begin
          // Release wins: no repeat can fire on the release tick.
          rpt_d[k]  = ST_IDLE;
          rcnt_d[k] = {RCNT_W{1'b0}};
        end else begin
          case (rpt_q[k])
            ST_IDLE: begin
              if (press_d[k]) begin
                rpt_d[k]  = ST_HOLD;
                rcnt_d[k] = {RCNT_W{1'b0}};
              end else begin
                rpt_d[k] = ST_IDLE;
              end
            end
            ST_HOLD: begin
              if (rcnt_q[k] == HOLD_LAST) begin
                repeat_d[k] = 1'b1;
                rcnt_d[k]   = {RCNT_W{1'b0}};
                rpt_d[k]    = ST_RPT;
              end else begin
                rcnt_d[k] = rcnt_q[k] + RCNT_W'(1);
              end
            end
            ST_RPT: begin
              if (rcnt_q[k] == RPT_LAST) begin
                repeat_d[k] = 1'b1;
                rcnt_d[k]   = {RCNT_W{1'b0}};
              end else begin
                rcnt_d[k] = rcnt_q[k] + RCNT_W'(1);
              end
            end
            default: begin
              rpt_d[k]  = ST_IDLE;
              rcnt_d[k] = {RCNT_W{1'b0}};
            end
          endcase
        end
      end
    end else begin
      repeat_d = {N_BTN{1'b0}};
    end
  end

  // Auto-repeat state, counter and pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      repeat_q <= {N_BTN{1'b0}};
      for (int k = 0; k < N_BTN; k++) begin
        rpt_q[k]  <= ST_IDLE;
        rcnt_q[k] <= {RCNT_W{1'b0}};
      end
    end else begin
      repeat_q <= repeat_d;
      for (int k = 0; k < N_BTN; k++) begin
        rpt_q[k]  <= rpt_d[k];
        rcnt_q[k] <= rcnt_d[k];
      end
    end
  end

  assign bus_if.o_repeat = repeat_q;

`else

  assign bus_if.o_repeat = {N_BTN{1'b0}};

`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// ----------------------------------------------------------------------------
// tb_btn_debounce_multi
// Directed and random stimulus for btn_debounce_multi with N_BTN=2,
// STABLE_TICKS=5, HOLD_TICKS=3, REPEAT_TICKS=2. The reference model keeps
// the history of sampled inputs per tick and flips the debounced level when
// the last STABLE_TICKS synchronised samples all disagree with it; repeats
// are derived from the distance in ticks to the last press.
// ----------------------------------------------------------------------------
module tb_btn_debounce_multi;

  localparam int N  = 2;
  localparam int ST = 5;
  localparam int HT = 3;
  localparam int RT = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  btn_debounce_multi_if #(.N_BTN(N)) bus ();

  btn_debounce_multi #(
    .N_BTN        (N),
    .STABLE_TICKS (ST),
    .HOLD_TICKS   (HT),
    .REPEAT_TICKS (RT)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_if (bus)
  );

  // reference model state
  logic [N-1:0] hist [$];
  logic [N-1:0] m_state, m_press, m_rel, m_rep;
  int           tk;
  int           ptick [N];

  // bookkeeping
  int errors = 0;
  int checks = 0;
  int obs_press [N];
  int obs_rel   [N];
  int obs_rep   [N];
  int first_press_tk [N];
  int first_rep_tk   [N];
  int consec;
  logic [N-1:0] prev_press, prev_rel, prev_rep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < ST + 2; i++) hist.push_back('0);
    m_state = '0;
    tk      = 0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin
      obs_press[k] = 0; obs_rel[k] = 0; obs_rep[k] = 0;
      first_press_tk[k] = -1; first_rep_tk[k] = -1;
    end
    consec = 0;
  endtask

  // one clock: drive, update model, then compare all outputs
  task automatic cyc(input logic e, input logic [N-1:0] b, input logic r);
    bus.i_ena = e;
    bus.i_btn = b;
    rst       = r;
    @(posedge clk);
    m_press = '0; m_rel = '0; m_rep = '0;
    if (r) begin
      model_reset();
    end else if (e) begin
      tk++;
      for (int k = 0; k < N; k++) begin
        bit flip;
        flip = 1'b1;
        // synchronised value used at this tick is the sample from two ticks ago
        for (int j = 0; j < ST; j++)
          if (hist[hist.size() - 2 - j][k] == m_state[k]) flip = 1'b0;
        if (flip) begin
          if (m_state[k] == 1'b0) begin
            m_press[k] = 1'b1;
            ptick[k]   = tk;
          end else begin
            m_rel[k] = 1'b1;
          end
          m_state[k] = ~m_state[k];
        end
`ifdef BTN_AUTO_REPEAT_EN
        if (m_state[k] && !m_press[k]) begin
          int d;
          d = tk - ptick[k];
          if (d >= HT && ((d - HT) % RT) == 0) m_rep[k] = 1'b1;
        end
`endif
      end
      hist.push_back(b);
      if (hist.size() > ST + 4) void'(hist.pop_front());
    end
    #1;
    chk("o_state",   bus.o_state,   m_state);
    chk("o_press",   bus.o_press,   m_press);
    chk("o_release", bus.o_release, m_rel);
    chk("o_repeat",  bus.o_repeat,  m_rep);
    for (int k = 0; k < N; k++) begin
      if (bus.o_press[k]) begin
        obs_press[k]++;
        if (first_press_tk[k] < 0) first_press_tk[k] = tk;
      end
      if (bus.o_release[k]) obs_rel[k]++;
      if (bus.o_repeat[k]) begin
        obs_rep[k]++;
        if (first_rep_tk[k] < 0) first_rep_tk[k] = tk;
      end
    end
    consec += $countones(bus.o_press & prev_press) + $countones(bus.o_release & prev_rel)
            + $countones(bus.o_repeat & prev_rep);
    prev_press = bus.o_press;
    prev_rel   = bus.o_release;
    prev_rep   = bus.o_repeat;
  endtask

  // n ticks with i_ena every 4 clocks
  task automatic ticks(input int n, input logic [N-1:0] b);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, b, 1'b0);
      cyc(1'b0, b, 1'b0);
      cyc(1'b0, b, 1'b0);
      cyc(1'b1, b, 1'b0);
    end
  endtask

  initial begin
    int base;
    logic [N-1:0] snap;
    logic [N-1:0] rb;
    int hold;

    prev_press = '0; prev_rel = '0; prev_rep = '0;
    for (int k = 0; k < N; k++) ptick[k] = 0;
    model_reset();
    clear_counts();

    // reset held 3 clocks with both buttons pressed, i_ena high to show priority
    cyc(1'b1, 2'b11, 1'b1);
    cyc(1'b1, 2'b11, 1'b1);
    cyc(1'b1, 2'b11, 1'b1);
    chk("rst_outputs", {bus.o_state, bus.o_press, bus.o_release, bus.o_repeat}, 8'h00);
    clear_counts();
    ticks(10, 2'b11);
    chk("rst_press_tick0", first_press_tk[0], 7);
    chk("rst_press_tick1", first_press_tk[1], 7);
    chk("rst_press_cnt",   obs_press[0] + obs_press[1], 2);
    chk("rst_state",       bus.o_state, 2'b11);

    // clean press on ch0 from a fresh reset
    cyc(1'b0, 2'b00, 1'b1);
    ticks(3, 2'b00);
    clear_counts();
    base = tk;
    ticks(10, 2'b01);
    chk("clean_tick",   first_press_tk[0] - base, 7);
    chk("clean_cnt0",   obs_press[0], 1);
    chk("clean_cnt1",   obs_press[1] + obs_rel[1], 0);
    chk("clean_state",  bus.o_state, 2'b01);

    // bounce on ch0
    ticks(10, 2'b00);
    clear_counts();
    ticks(1, 2'b01);
    ticks(1, 2'b00);
    ticks(1, 2'b01);
    ticks(1, 2'b00);
    base = tk;
    ticks(10, 2'b01);
    chk("bounce_cnt",  obs_press[0], 1);
    chk("bounce_tick", first_press_tk[0] - base, 7);

    // glitch on ch1: 4-tick drop is rejected, 5-tick drop is accepted
    ticks(10, 2'b11);
    clear_counts();
    ticks(4, 2'b01);
    ticks(10, 2'b11);
    chk("glitch4_rel",   obs_rel[1], 0);
    chk("glitch4_state", bus.o_state[1], 1'b1);
    clear_counts();
    ticks(5, 2'b01);
    ticks(10, 2'b11);
    chk("glitch5_rel",   obs_rel[1], 1);

    // auto-repeat on ch0; release lands on a tick where a repeat would be due
    ticks(10, 2'b00);
    clear_counts();
    ticks(21, 2'b01);
    ticks(10, 2'b00);
    chk("hold_rel", obs_rel[0], 1);
`ifdef BTN_AUTO_REPEAT_EN
    chk("rpt_first", first_rep_tk[0] - first_press_tk[0], 3);
    chk("rpt_cnt",   obs_rep[0], 9);
`else
    chk("rpt_none",  obs_rep[0] + obs_rep[1], 0);
`endif

    // enable gating: 100 clocks without ticks while inputs toggle
    ticks(2, 2'b10);
    ticks(10, 2'b10);
    clear_counts();
    snap = bus.o_state;
    for (int i = 0; i < 100; i++) cyc(1'b0, N'($urandom), 1'b0);
    chk("gate_pulses", obs_press[0] + obs_press[1] + obs_rel[0] + obs_rel[1], 0);
    chk("gate_state",  bus.o_state, snap);

    // continuous i_ena: pulses must still be single clocks
    clear_counts();
    hold = 0;
    rb = '0;
    for (int i = 0; i < 300; i++) begin
      if (hold == 0) begin
        rb   = N'($urandom);
        hold = $urandom_range(1, 14);
      end
      hold--;
      cyc(1'b1, rb, 1'b0);
    end
    chk("cont_one_clk", consec, 0);

    // random phase with sparse ticks and occasional reset
    clear_counts();
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        rb   = N'($urandom);
        hold = $urandom_range(1, 40);
      end
      hold--;
      cyc(($urandom_range(0, 2) == 0), rb, ($urandom_range(0, 499) == 0));
    end
    chk("rand_one_clk", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
